// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS32 controller.
// Optional macro MC_BNE_EN (see mc_controller) adds bne support.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_FAULT   = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    AOP_NONE  = 2'd0,
    AOP_ADD   = 2'd1,
    AOP_SUB   = 2'd2,
    AOP_FUNCT = 2'd3
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_mem_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) ||
           (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode: maps state class and funct to alucontrol.
// Flags unsupported funct codes so the FSM can fault.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  always_comb begin
    alucontrol = ALU_AND;
    illegal    = 1'b0;
    unique case (alu_op)
      AOP_NONE: alucontrol = ALU_AND;
      AOP_ADD:  alucontrol = ALU_ADD;
      AOP_SUB:  alucontrol = ALU_SUB;
      AOP_FUNCT: begin
        unique case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS32 control FSM with memory wait timeout.
// Define MC_BNE_EN to accept bne through the BRANCH state.
module mc_controller
  import mc_pkg::*;
#(
  parameter int WAIT_MAX  = 8,
  parameter int CNT_W     = 8,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instruct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_src,
  output logic                 pc_en,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic [3:0]           state_o,
  output logic                 fault
);

  state_t           state;
  state_t           state_nx;
  state_t           dec_st;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nx;
  logic             fault_q;
  logic             wait_st;
  logic             timeout;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             is_bne;
  alu_op_t          alu_op;
  logic [2:0]       alu_ctl;
  logic             bad_funct;
  logic             unused_bits;

  assign op          = instruct[31:26];
  assign funct       = instruct[5:0];
  assign unused_bits = ^instruct[25:6];

`ifdef MC_BNE_EN
  assign is_bne = (op == OP_BNE);
`else
  assign is_bne = 1'b0;
`endif

  mc_alu_decoder u_alu_dec (
    .alu_op     (alu_op),
    .funct      (funct),
    .alucontrol (alu_ctl),
    .illegal    (bad_funct)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (state_nx == S_FAULT)
        fault_q <= 1'b1;
    end
  end

  assign wait_st = is_mem_wait(state);
  assign timeout = wait_st && !mem_ready &&
    (wait_cnt == CNT_W'(WAIT_MAX - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:
        if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):    state_nx = S_MEMADR;
          (op == OP_RTYPE): state_nx = S_EXECUTE;
          (op == OP_BEQ),
          is_bne:           state_nx = S_BRANCH;
          (op == OP_ADDI):  state_nx = S_ADDIEX;
          (op == OP_J):     state_nx = S_JUMP;
          default:          state_nx = S_FAULT;
        endcase
      end
      S_MEMADR:
        state_nx = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:
        if (mem_ready) state_nx = S_MEMWB;
      S_MEMWR:
        if (mem_ready) state_nx = S_FETCH;
      S_EXECUTE:
        state_nx = bad_funct ? S_FAULT : S_ALUWB;
      S_ADDIEX:
        state_nx = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH,
      S_ADDIWB, S_JUMP:
        state_nx = S_FETCH;
      S_FAULT:
        state_nx = S_FAULT;
      default:
        state_nx = S_FAULT;
    endcase
    // completion beats timeout since timeout needs !mem_ready
    if (timeout) state_nx = S_FAULT;
  end

  always_comb begin
    wait_nx = wait_cnt;
    if (state_nx != state)
      wait_nx = '0;
    else if (wait_st && !mem_ready &&
             wait_cnt != CNT_W'(WAIT_MAX))
      wait_nx = wait_cnt + CNT_W'(1);
  end

  assign dec_st = reset ? S_FETCH : state;

  always_comb begin
    mem_req    = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PC_ALU;
    pc_en      = 1'b0;
    alu_op     = AOP_NONE;
    unique case (dec_st)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = AOP_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = AOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = AOP_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = AOP_SUB;
        pc_src    = PC_ALUOUT;
        pc_en     = zero ^ is_bne;
      end
      S_ADDIWB:
        reg_write = 1'b1;
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    // reset aborts any access in flight
    if (reset) begin
      mem_req   = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      pc_en     = 1'b0;
    end
  end

  assign alucontrol = ALUCTRL_W'(alu_ctl);
  assign state_o    = state;
  assign fault      = fault_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: random instruction stream vs a
// per-instruction state-sequence model plus directed corner cases.
module tb_mc_controller;

  localparam int K_LW   = 0;
  localparam int K_SW   = 1;
  localparam int K_R    = 2;
  localparam int K_BEQ  = 3;
  localparam int K_ADDI = 4;
  localparam int K_J    = 5;
  localparam int K_BNE  = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, iord, ir_write, mem_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic        pc_en, fault;
  logic [2:0]  alucontrol;
  logic [3:0]  state_o;
  logic [15:0] obs;

  int          total = 0;
  int          bad = 0;
  bit          exp_fault = 1'b0;
  bit          bne_e = 1'b0;
  logic [2:0]  rop_e = 3'b000;
  logic [15:0] omask = 16'hffff;
  logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  logic [2:0]  acs [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .instruct   (instruct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .iord       (iord),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .alucontrol (alucontrol),
    .state_o    (state_o),
    .fault      (fault)
  );

  assign obs = {mem_req, iord, ir_write, mem_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, pc_src, pc_en, alucontrol};

  initial begin
    #300000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int rwait();
    if ($urandom_range(0, 9) == 0) return 7;
    return int'($urandom_range(0, 3));
  endfunction

  function automatic logic [5:0] op_of(int k);
    case (k)
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_R:     return 6'b000000;
      K_BEQ:   return 6'b000100;
      K_ADDI:  return 6'b001000;
      K_J:     return 6'b000010;
      default: return 6'b000101;
    endcase
  endfunction

  // Output table per state, straight from the state listing.
  function automatic logic [15:0] exp_out(
    int st, bit mr, bit z, bit rst);
    logic mq = 0, io = 0, irw = 0, mw = 0, m2r = 0;
    logic rd = 0, rw = 0, sa = 0, pe = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] ac = 0;
    int s = rst ? 0 : st;
    case (s)
      0: begin mq = 1; sb = 2'b01; ac = 3'b010;
               irw = mr; pe = mr; end
      1: begin sb = 2'b11; ac = 3'b010; end
      2: begin sa = 1; sb = 2'b10; ac = 3'b010; end
      3: begin mq = 1; io = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mq = 1; io = 1; mw = mr; end
      6: begin sa = 1; ac = rop_e; end
      7: begin rw = 1; rd = 1; end
      8: begin sa = 1; ac = 3'b110; ps = 2'b01;
               pe = z ^ bne_e; end
      9: begin sa = 1; sb = 2'b10; ac = 3'b010; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    if (rst) begin
      irw = 0; mw = 0; rw = 0; pe = 0; mq = 0;
    end
    return {mq, io, irw, mw, m2r, rd, rw, sa,
            sb, ps, pe, ac};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, o, e);
    end
  endtask

  task automatic step(input int st, input bit mr,
                      input bit z, input bit rst,
                      input string tag);
    logic [15:0] e;
    @(negedge clk);
    reset = rst;
    mem_ready = mr;
    zero = z;
    #1;
    e = exp_out(st, mr, z, rst);
    chk({tag, ":state"}, 32'(state_o), 32'(st));
    chk({tag, ":outs"}, 32'(obs & omask), 32'(e & omask));
    chk({tag, ":fault"}, 32'(fault), 32'(exp_fault));
  endtask

  task automatic fetch_decode(input logic [31:0] ins,
                              input int fw,
                              input string tag);
    for (int i = 0; i < fw; i++) step(0, 0, rb(), 0, tag);
    step(0, 1, rb(), 0, tag);
    instruct = ins;
    step(1, rb(), rb(), 0, tag);
  endtask

  task automatic run_instr(input int k, input int fi,
                           input bit bz, input int fw,
                           input int mw, input string tag);
    logic [5:0] fn;
    fn = 6'($urandom);
    if (k == K_R) begin
      fn = fns[fi];
      rop_e = acs[fi];
    end
    bne_e = (k == K_BNE);
    fetch_decode({op_of(k), 20'($urandom), fn}, fw, tag);
    case (k)
      K_LW: begin
        step(2, rb(), rb(), 0, tag);
        for (int i = 0; i < mw; i++) step(3, 0, rb(), 0, tag);
        step(3, 1, rb(), 0, tag);
        step(4, rb(), rb(), 0, tag);
      end
      K_SW: begin
        step(2, rb(), rb(), 0, tag);
        for (int i = 0; i < mw; i++) step(5, 0, rb(), 0, tag);
        step(5, 1, rb(), 0, tag);
      end
      K_R: begin
        step(6, rb(), rb(), 0, tag);
        step(7, rb(), rb(), 0, tag);
      end
      K_BEQ, K_BNE: step(8, rb(), bz, 0, tag);
      K_ADDI: begin
        step(9, rb(), rb(), 0, tag);
        step(10, rb(), rb(), 0, tag);
      end
      default: step(11, rb(), rb(), 0, tag);
    endcase
  endtask

  task automatic reset_from(input int st, input string tag);
    step(st, 1, rb(), 1, tag);
    exp_fault = 1'b0;
  endtask

  initial begin
    int k;
    step(0, 1, rb(), 1, "rst0");
    step(0, 1, rb(), 1, "rst1");

    run_instr(K_LW, 0, 0, 0, 0, "lw");
    run_instr(K_R, 0, 0, 0, 0, "add");
    run_instr(K_R, 1, 0, 0, 0, "sub");
    run_instr(K_R, 4, 0, 0, 0, "slt");
    run_instr(K_BEQ, 0, 1, 0, 0, "beq_z1");
    run_instr(K_BEQ, 0, 0, 0, 0, "beq_z0");
    run_instr(K_ADDI, 0, 0, 3, 0, "fetch_w3");
    run_instr(K_LW, 0, 0, 7, 7, "lw_edge");
    run_instr(K_SW, 0, 0, 0, 7, "sw_edge");
    run_instr(K_J, 0, 0, 0, 0, "j");

    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 5));
      run_instr(k, int'($urandom_range(0, 4)), rb(),
                rwait(), rwait(), "rnd");
    end

`ifdef MC_BNE_EN
    run_instr(K_BNE, 0, 1, 0, 0, "bne_z1");
    run_instr(K_BNE, 0, 0, 0, 0, "bne_z0");
    bne_e = 1'b0;
`else
    fetch_decode({6'b000101, 26'($urandom)}, 0, "bne_ill");
    exp_fault = 1'b1;
    step(15, rb(), rb(), 0, "bne_ill");
    reset_from(15, "bne_rst");
`endif

    fetch_decode({6'b111111, 26'($urandom)}, 0, "op_ill");
    exp_fault = 1'b1;
    step(15, rb(), rb(), 0, "op_ill");
    step(15, rb(), rb(), 0, "op_hold");
    reset_from(15, "op_rst");

    // unsupported funct: alucontrol in EXECUTE is left unchecked
    fetch_decode({6'b000000, 20'($urandom), 6'h3f}, 0, "fn_ill");
    omask = 16'hfff8;
    step(6, rb(), rb(), 0, "fn_ill");
    omask = 16'hffff;
    exp_fault = 1'b1;
    step(15, rb(), rb(), 0, "fn_ill");
    reset_from(15, "fn_rst");

    fetch_decode({6'b100011, 26'($urandom)}, 0, "to_rd");
    step(2, rb(), rb(), 0, "to_rd");
    for (int i = 0; i < 8; i++) step(3, 0, rb(), 0, "to_rd");
    exp_fault = 1'b1;
    for (int i = 0; i < 3; i++)
      step(15, rb(), rb(), 0, "to_hold");
    reset_from(15, "to_rst");
    step(0, 0, rb(), 0, "to_after");

    for (int i = 0; i < 7; i++) step(0, 0, rb(), 0, "to_fe");
    exp_fault = 1'b1;
    step(15, rb(), rb(), 0, "to_fe");
    reset_from(15, "to_fe_rst");

    fetch_decode({6'b101011, 26'($urandom)}, 0, "sw_rst");
    step(2, rb(), rb(), 0, "sw_rst");
    reset_from(5, "sw_rst");
    run_instr(K_ADDI, 0, 0, 0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
